// File: rtl/x_mem_2p_clr.sv
// ---------------------------------------------------------------------------
// x_mem_2p_clr
//   Simple dual-port (one write, one read) memory with a built-in clear engine.
//   After reset release, or after an accepted i_clr, the engine writes CLR_VAL
//   to every word, one address per cycle, ascending. User accesses are ignored
//   while the engine runs (o_busy=1).
//
// Parameters
//   WIDTH    data bits per word
//   DEPTH    number of words (2..65536, need not be a power of two)
//   RDW_MODE same-address read-during-write: 0 = old data, 1 = new data
//   CLR_VAL  value written to every word by the clear engine
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (restarts the clear)
//   i_we     write enable        i_waddr  write address
//   i_wdata  write data          i_wmask  per-bit write enable
//   i_re     read enable         i_raddr  read address
//   o_rdata  registered read data, valid with o_rvalid (latency 1)
//   o_rvalid o_rdata updated this cycle
//   i_clr    request a full-memory clear (ignored while busy)
//   o_busy   clear in progress
// ---------------------------------------------------------------------------
module x_mem_2p_clr #(
  parameter int              WIDTH    = 2,
  parameter int              DEPTH    = 2048,
  parameter int              RDW_MODE = 0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  localparam int             AW       = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_wmask,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  input  logic             i_clr,
  output logic             o_busy
);

  // One extra bit so DEPTH itself is representable (e.g. DEPTH=65536, AW=16).
  localparam logic [AW:0]    DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  LAST_ADR = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q;
  logic             clr_last;

  logic             waddr_ok, raddr_ok;
  logic             user_ok, user_we, rd_en;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data, wr_mask;
  logic [WIDTH-1:0] rd_word;

  logic [WIDTH-1:0] mem [DEPTH];

  assign clr_last = (clr_cnt_q == LAST_ADR);
  assign waddr_ok = ({1'b0, i_waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, i_raddr} < DEPTH_W);

  // -------------------------------------------------------------------------
  // FSM: state register (with the clear address counter)
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Counter sits at 0 outside a clear, so the next clear starts at 0.
      if (state_q == ST_CLEAR && !clr_last) clr_cnt_q <= clr_cnt_q + AW'(1);
      else                                  clr_cnt_q <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      ST_IDLE:  if (i_clr)    state_d = ST_CLEAR;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs -- the single write port is shared by the clear engine and
  // the user; the engine owns it whenever busy.
  // -------------------------------------------------------------------------
  always_comb begin
    o_busy  = (state_q == ST_CLEAR);
    user_ok = !o_busy && !i_rst;
    user_we = user_ok && i_we && waddr_ok;
    rd_en   = user_ok && i_re;
    wr_en   = 1'b0;
    wr_addr = i_waddr;
    wr_data = i_wdata;
    wr_mask = i_wmask;
    if (o_busy && !i_rst) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = CLR_VAL;
      wr_mask = '1;
    end else if (user_we) begin
      wr_en   = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Memory array, bit-masked write
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; the clear engine is its only initialiser,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (wr_mask[k]) mem[wr_addr][k] <= wr_data[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path. Out-of-range reads return CLR_VAL. With RDW_MODE=1 a
  // same-address user write is forwarded as the masked merge; an out-of-range
  // address never forwards because that write is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_word = CLR_VAL;
    if (raddr_ok) rd_word = mem[i_raddr];
    if (RDW_MODE != 0 && user_we && (i_waddr == i_raddr))
      rd_word = (rd_word & ~i_wmask) | (i_wdata & i_wmask);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= rd_en;
      if (rd_en) o_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_x_mem_2p_clr.sv
// ---------------------------------------------------------------------------
// tb_x_mem_2p_clr
//   Three instances: a (DEPTH 2048, old-data RDW), b (same, new-data RDW,
//   sharing a's inputs) and c (DEPTH 1000, CLR_VAL 2'b01). A behavioural
//   array model predicts every read; directed steps plus random traffic.
// ---------------------------------------------------------------------------
module tb_x_mem_2p_clr;

  localparam logic [1:0] CLR_AB = 2'b00;
  localparam logic [1:0] CLR_C  = 2'b01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ab_we, ab_re, ab_clr;
  logic [10:0] ab_waddr, ab_raddr;
  logic [1:0]  ab_wdata, ab_wmask;
  logic [1:0]  a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_busy, b_busy;

  logic        c_we, c_re, c_clr;
  logic [9:0]  c_waddr, c_raddr;
  logic [1:0]  c_wdata, c_wmask, c_rdata;
  logic        c_rvalid, c_busy;

  x_mem_2p_clr #(.WIDTH(2), .DEPTH(2048), .RDW_MODE(0), .CLR_VAL(CLR_AB)) u_a (
    .i_clk(clk), .i_rst(rst), .i_we(ab_we), .i_waddr(ab_waddr), .i_wdata(ab_wdata),
    .i_wmask(ab_wmask), .i_re(ab_re), .i_raddr(ab_raddr), .o_rdata(a_rdata),
    .o_rvalid(a_rvalid), .i_clr(ab_clr), .o_busy(a_busy));

  x_mem_2p_clr #(.WIDTH(2), .DEPTH(2048), .RDW_MODE(1), .CLR_VAL(CLR_AB)) u_b (
    .i_clk(clk), .i_rst(rst), .i_we(ab_we), .i_waddr(ab_waddr), .i_wdata(ab_wdata),
    .i_wmask(ab_wmask), .i_re(ab_re), .i_raddr(ab_raddr), .o_rdata(b_rdata),
    .o_rvalid(b_rvalid), .i_clr(ab_clr), .o_busy(b_busy));

  x_mem_2p_clr #(.WIDTH(2), .DEPTH(1000), .RDW_MODE(0), .CLR_VAL(CLR_C)) u_c (
    .i_clk(clk), .i_rst(rst), .i_we(c_we), .i_waddr(c_waddr), .i_wdata(c_wdata),
    .i_wmask(c_wmask), .i_re(c_re), .i_raddr(c_raddr), .o_rdata(c_rdata),
    .o_rvalid(c_rvalid), .i_clr(c_clr), .o_busy(c_busy));

  int tests = 0;
  int fails = 0;

  logic [1:0] m_ab [2048];
  logic [1:0] m_c  [1000];
  logic [1:0] hold_a, hold_b, hold_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] merge(input logic [1:0] old, input logic [1:0] d,
                                       input logic [1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  task automatic fill_ab();
    foreach (m_ab[i]) m_ab[i] = CLR_AB;
  endtask

  task automatic fill_c();
    foreach (m_c[i]) m_c[i] = CLR_C;
  endtask

  // One user cycle on a/b while idle; clr=1 means the clear is expected to
  // start, so busy must be high afterwards.
  task automatic cyc_ab(input logic we, input logic [10:0] wa, input logic [1:0] wd,
                        input logic [1:0] wm, input logic re, input logic [10:0] ra,
                        input logic clr, input string tag);
    logic [1:0] old;
    ab_we = we; ab_waddr = wa; ab_wdata = wd; ab_wmask = wm;
    ab_re = re; ab_raddr = ra; ab_clr = clr;
    old = m_ab[ra];
    if (re) begin
      hold_a = old;
      hold_b = (we && wa == ra) ? merge(old, wd, wm) : old;
    end
    if (we) m_ab[wa] = merge(m_ab[wa], wd, wm);
    step();
    check($sformatf("%s a_rvalid", tag), a_rvalid, re);
    check($sformatf("%s a_rdata", tag), a_rdata, hold_a);
    check($sformatf("%s b_rvalid", tag), b_rvalid, re);
    check($sformatf("%s b_rdata", tag), b_rdata, hold_b);
    check($sformatf("%s a_busy", tag), a_busy, clr);
    ab_we = 1'b0; ab_re = 1'b0; ab_clr = 1'b0;
  endtask

  task automatic cyc_c(input logic we, input logic [9:0] wa, input logic [1:0] wd,
                       input logic [1:0] wm, input logic re, input logic [9:0] ra,
                       input string tag);
    c_we = we; c_waddr = wa; c_wdata = wd; c_wmask = wm;
    c_re = re; c_raddr = ra; c_clr = 1'b0;
    if (re) hold_c = (int'(ra) < 1000) ? m_c[ra] : CLR_C;
    if (we && int'(wa) < 1000) m_c[wa] = merge(m_c[wa], wd, wm);
    step();
    check($sformatf("%s c_rvalid", tag), c_rvalid, re);
    check($sformatf("%s c_rdata", tag), c_rdata, hold_c);
    check($sformatf("%s c_busy", tag), c_busy, 1'b0);
    c_we = 1'b0; c_re = 1'b0;
  endtask

  // Drop reset and count how many sample points each instance stays busy.
  task automatic release_and_count(input string tag);
    int na, nb, nc;
    na = 0; nb = 0; nc = 0;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_busy && !b_busy && !c_busy) break;
      na += int'(a_busy);
      nb += int'(b_busy);
      nc += int'(c_busy);
      step();
    end
    check($sformatf("%s a busy cycles", tag), na, 2048);
    check($sformatf("%s b busy cycles", tag), nb, 2048);
    check($sformatf("%s c busy cycles", tag), nc, 1000);
    fill_ab();
    fill_c();
  endtask

  task automatic reset_checks(input string tag);
    check($sformatf("%s a_busy", tag), a_busy, 1'b1);
    check($sformatf("%s a_rvalid", tag), a_rvalid, 1'b0);
    check($sformatf("%s a_rdata", tag), a_rdata, 2'b00);
    check($sformatf("%s b_rdata", tag), b_rdata, 2'b00);
    check($sformatf("%s c_busy", tag), c_busy, 1'b1);
    check($sformatf("%s c_rvalid", tag), c_rvalid, 1'b0);
    check($sformatf("%s c_rdata", tag), c_rdata, 2'b00);
    hold_a = 2'b00; hold_b = 2'b00; hold_c = 2'b00;
  endtask

  initial begin
    int n, bad;
    rst = 1'b1;
    ab_we = 0; ab_re = 0; ab_clr = 0; ab_waddr = '0; ab_raddr = '0; ab_wdata = '0; ab_wmask = '0;
    c_we = 0; c_re = 0; c_clr = 0; c_waddr = '0; c_raddr = '0; c_wdata = '0; c_wmask = '0;

    // Reset state, then initial clear length.
    repeat (3) step();
    reset_checks("reset");
    release_and_count("init");

    // Reads of the cleared array at the ends and middle.
    cyc_ab(0, 0, 0, 0, 1, 11'd0,    0, "rd0");
    cyc_ab(0, 0, 0, 0, 1, 11'd1023, 0, "rd1023");
    cyc_ab(0, 0, 0, 0, 1, 11'd2047, 0, "rd2047");
    check("rd2047 const", a_rdata, CLR_AB);
    cyc_c(0, 0, 0, 0, 1, 10'd0,   "c rd0");
    cyc_c(0, 0, 0, 0, 1, 10'd999, "c rd999");

    // Bit-masked writes.
    cyc_ab(1, 11'd5, 2'b11, 2'b11, 0, 0, 0, "mask w1");
    cyc_ab(1, 11'd5, 2'b00, 2'b10, 0, 0, 0, "mask w2");
    cyc_ab(0, 0, 0, 0, 1, 11'd5, 0, "mask rd");
    check("mask rd const", a_rdata, 2'b01);

    // Same-address read during write.
    cyc_ab(1, 11'd9, 2'b10, 2'b11, 0, 0, 0, "rdw pre");
    cyc_ab(1, 11'd9, 2'b01, 2'b11, 1, 11'd9, 0, "rdw");
    check("rdw old const", a_rdata, 2'b10);
    check("rdw new const", b_rdata, 2'b01);
    cyc_ab(0, 0, 0, 0, 1, 11'd9, 0, "rdw after");
    check("rdw after const", a_rdata, 2'b01);

    // Out-of-range on the non-power-of-two instance.
    cyc_c(1, 10'd1010, 2'b11, 2'b11, 0, 0, "c oor w");
    cyc_c(0, 0, 0, 0, 1, 10'd1010, "c oor rd");
    check("c oor const", c_rdata, CLR_C);
    cyc_c(1, 10'd999, 2'b11, 2'b11, 0, 0, "c w999");
    cyc_c(0, 0, 0, 0, 1, 10'd999, "c rd999b");
    check("c rd999 const", c_rdata, 2'b11);

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] wa, ra;
      wa = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047));
      ra = ($urandom_range(0, 3) == 0) ? wa
         : (($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047)));
      cyc_ab(1'($urandom_range(0, 1)), wa, 2'($urandom), 2'($urandom),
             1'($urandom_range(0, 1)), ra, 0, "rand ab");
    end
    for (int i = 0; i < 300; i++) begin
      logic [9:0] wa, ra;
      wa = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom_range(0, 1023));
      ra = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom_range(0, 1023));
      cyc_c(1'($urandom_range(0, 1)), wa, 2'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), ra, "rand c");
    end

    // Clear request together with a user access: access happens, clear follows.
    cyc_ab(1, 11'd7, 2'b11, 2'b11, 1, 11'd7, 1, "clr+access");
    n = 0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_busy) break;
      n++;
      ab_we = 1'b1; ab_waddr = 11'd0; ab_wdata = 2'b11; ab_wmask = 2'b11;
      ab_re = 1'b1; ab_raddr = 11'd0;
      ab_clr = (n == 10);
      step();
      if (a_busy && (a_rvalid !== 1'b0 || a_rdata !== hold_a || b_rvalid !== 1'b0)) bad++;
    end
    ab_we = 1'b0; ab_re = 1'b0; ab_clr = 1'b0;
    check("clr busy cycles", n, 2048);
    check("busy gating errors", bad, 0);
    fill_ab();
    cyc_ab(0, 0, 0, 0, 1, 11'd0, 0, "after clr rd0");
    cyc_ab(0, 0, 0, 0, 1, 11'd7, 0, "after clr rd7");

    // Dirty the array again, then reset in the middle of a clear.
    for (int i = 0; i < 300; i++)
      cyc_ab(1, 11'($urandom_range(0, 2047)), 2'b11, 2'b11, 0, 0, 0, "dirty");
    cyc_ab(0, 0, 0, 0, 0, 0, 1, "clr2");
    repeat (700) step();
    rst = 1'b1;
    repeat (2) step();
    reset_checks("mid reset");
    release_and_count("restart");
    for (int i = 0; i < 2048; i++) cyc_ab(0, 0, 0, 0, 1, 11'(i), 0, "sweep ab");
    for (int i = 0; i < 1000; i++) cyc_c(0, 0, 0, 0, 1, 10'(i), "sweep c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
